// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, access-size decode,
// funct3 legality and the controller FSM state encoding.
package lsu_ctrl_pkg;

  // RISC-V LOAD funct3 codes
  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Ld  = 3'b011;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;
  localparam logic [2:0] Funct3Lwu = 3'b110;

  // RISC-V STORE funct3 codes
  localparam logic [2:0] Funct3Sb = 3'b000;
  localparam logic [2:0] Funct3Sh = 3'b001;
  localparam logic [2:0] Funct3Sw = 3'b010;
  localparam logic [2:0] Funct3Sd = 3'b011;

  typedef enum logic [2:0] {
    StIdle,
    StCmd0,
    StRsp0,
    StCmd1,
    StRsp1,
    StDone
  } state_e;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  // Doubleword and LWU only exist on a 64-bit datapath.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3,
                                        input logic rv64);
    if (we) begin
      return (funct3 == Funct3Sb) || (funct3 == Funct3Sh) || (funct3 == Funct3Sw) ||
             (rv64 && (funct3 == Funct3Sd));
    end
    return (funct3 != 3'b111) && (rv64 || ((funct3 != Funct3Ld) && (funct3 != Funct3Lwu)));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane datapath: store strobe/data shifting and load
// extraction with sign/zero extension. The second-beat ports exist only when
// LSU_MISALIGN_EN is defined.
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned NB = XLEN / 8,
  localparam int unsigned OFFW = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic [OFFW-1:0] off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata0,
  output logic [NB-1:0]   wstrb0,
  output logic [XLEN-1:0] wdata0,
`ifdef LSU_MISALIGN_EN
  input  logic [XLEN-1:0] rdata1,
  output logic [NB-1:0]   wstrb1,
  output logic [XLEN-1:0] wdata1,
`endif
  output logic [XLEN-1:0] ldata
);

  typedef logic [2*NB-1:0]   strb2_t;
  typedef logic [2*XLEN-1:0] data2_t;

  logic [3:0]      size;
  logic [7:0]      byte_mask;
  strb2_t          strb_full;
  data2_t          wdata_full;
  logic [XLEN-1:0] shifted;
  int unsigned     nbits;
  logic            sign_en;
  logic            sign_bit;

  assign size      = size_bytes(funct3);
  // 8'd1 << 8 wraps to 0, so a doubleword still yields 8'hFF.
  assign byte_mask = (8'd1 << size) - 8'd1;

  // Build strobes/data double-width; the upper half spills into the second beat.
  always_comb begin
    strb_full  = strb2_t'(byte_mask) << off;
    wdata_full = data2_t'(wdata) << {off, 3'b000};
    wstrb0     = strb_full[NB-1:0];
    wdata0     = wdata_full[XLEN-1:0];
`ifdef LSU_MISALIGN_EN
    wstrb1     = strb_full[2*NB-1:NB];
    wdata1     = wdata_full[2*XLEN-1:XLEN];
`endif
  end

  // Right-justify the loaded bytes, then extend above the access width.
  always_comb begin
`ifdef LSU_MISALIGN_EN
    shifted = XLEN'({rdata1, rdata0} >> {off, 3'b000});
`else
    shifted = rdata0 >> {off, 3'b000};
`endif
    nbits    = {25'd0, size, 3'b000};
    sign_en  = (funct3 == Funct3Lb) || (funct3 == Funct3Lh) || (funct3 == Funct3Lw);
    sign_bit = 1'b0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (i == nbits - 1) sign_bit = shifted[i];
    end
    for (int unsigned i = 0; i < XLEN; i++) begin
      ldata[i] = (i < nbits) ? shifted[i] : (sign_en & sign_bit);
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between execute and an aligned data-memory bus.
// One request outstanding; each request yields exactly one rsp_valid pulse.
// Define LSU_MISALIGN_EN to split bus-crossing accesses into two beats;
// otherwise misaligned accesses are rejected with rsp_err.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_err
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam logic        Rv64 = (XLEN == 64);

  state_e          state_q, state_d;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic            rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0]     tmo_q, tmo_d;
  logic            tmo_hit, req_bad;
  logic [OFFW-1:0] off;
  logic [XLEN-1:0] base_addr, rdata0_in, ldata, wdata0;
  logic [NB-1:0]   wstrb0;
`ifdef LSU_MISALIGN_EN
  logic [XLEN-1:0] rdata0_q, rdata1_in, wdata1;
  logic [NB-1:0]   wstrb1;
  logic            split;
`else
  logic [3:0]      req_size_m1;
`endif

  assign off       = addr_q[OFFW-1:0];
  assign base_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TIMEOUT - 1);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef LSU_MISALIGN_EN
  assign req_bad   = !funct3_legal(req_we, req_funct3, Rv64);
  assign split     = (32'(off) + 32'(size_bytes(funct3_q))) > NB;
  // In RSP1 the first beat comes from its register, the second straight off the bus.
  assign rdata0_in = (state_q == StRsp1) ? rdata0_q : mem_rdata;
  assign rdata1_in = (state_q == StRsp1) ? mem_rdata : '0;
`else
  assign req_size_m1 = size_bytes(req_funct3) - 4'd1;
  assign req_bad     = !funct3_legal(req_we, req_funct3, Rv64) ||
                       ((req_addr[OFFW-1:0] & req_size_m1[OFFW-1:0]) != '0);
  assign rdata0_in   = mem_rdata;
`endif

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .funct3 (funct3_q),
    .off    (off),
    .wdata  (wdata_q),
    .rdata0 (rdata0_in),
    .wstrb0 (wstrb0),
    .wdata0 (wdata0),
`ifdef LSU_MISALIGN_EN
    .rdata1 (rdata1_in),
    .wstrb1 (wstrb1),
    .wdata1 (wdata1),
`endif
    .ldata  (ldata)
  );

  // State, timeout counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tmo_q       <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Request latch on accept; first-beat read data capture for split loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef LSU_MISALIGN_EN
      rdata0_q <= '0;
`endif
    end else begin
      if (req_valid && (state_q == StIdle)) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
`ifdef LSU_MISALIGN_EN
      if ((state_q == StRsp0) && mem_rvalid) rdata0_q <= mem_rdata;
`endif
    end
  end

  // Next-state, timeout and response-value logic.
  always_comb begin
    state_d     = state_q;
    tmo_d       = '0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_bad) begin
            state_d     = StDone;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = StCmd0;
          end
        end
      end
      StCmd0: if (mem_ready) state_d = StRsp0;
      StRsp0: begin
        if (mem_rvalid) begin
          state_d     = StDone;
          rsp_err_d   = mem_err;
          rsp_rdata_d = (mem_err || we_q) ? '0 : ldata;
`ifdef LSU_MISALIGN_EN
          if (!mem_err && split) state_d = StCmd1;
`endif
        end else if (tmo_hit) begin
          state_d     = StDone;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + 32'd1;
        end
      end
`ifdef LSU_MISALIGN_EN
      StCmd1: if (mem_ready) state_d = StRsp1;
      StRsp1: begin
        if (mem_rvalid) begin
          state_d     = StDone;
          rsp_err_d   = mem_err;
          rsp_rdata_d = (mem_err || we_q) ? '0 : ldata;
        end else if (tmo_hit) begin
          state_d     = StDone;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + 32'd1;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and bus command outputs; bus fields read zero outside command states.
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StDone);
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (state_q == StCmd0) begin
      mem_valid = 1'b1;
      mem_we    = we_q;
      mem_addr  = base_addr;
      mem_wstrb = we_q ? wstrb0 : '0;
      mem_wdata = we_q ? wdata0 : '0;
    end
`ifdef LSU_MISALIGN_EN
    if (state_q == StCmd1) begin
      mem_valid = 1'b1;
      mem_we    = we_q;
      mem_addr  = base_addr + XLEN'(NB);
      mem_wstrb = we_q ? wstrb1 : '0;
      mem_wdata = we_q ? wdata1 : '0;
    end
`endif
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a 32-bit instance with TIMEOUT=4 and a 64-bit
// instance. Expected values are hand-computed constants.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // 32-bit instance
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  // 64-bit instance
  logic        r64_valid, r64_ready, r64_we, r64_rsp_valid, r64_rsp_err;
  logic [2:0]  r64_funct3;
  logic [63:0] r64_addr, r64_wdata, r64_rsp_rdata;
  logic        m64_valid, m64_ready, m64_we, m64_rvalid, m64_err;
  logic [63:0] m64_addr, m64_wdata, m64_rdata;
  logic [7:0]  m64_wstrb;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  lsu_ctrl #(.XLEN(64), .TIMEOUT(0)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(r64_valid), .req_ready(r64_ready), .req_we(r64_we),
    .req_funct3(r64_funct3), .req_addr(r64_addr), .req_wdata(r64_wdata),
    .rsp_valid(r64_rsp_valid), .rsp_err(r64_rsp_err), .rsp_rdata(r64_rsp_rdata),
    .mem_valid(m64_valid), .mem_ready(m64_ready), .mem_we(m64_we),
    .mem_addr(m64_addr), .mem_wstrb(m64_wstrb), .mem_wdata(m64_wdata),
    .mem_rvalid(m64_rvalid), .mem_rdata(m64_rdata), .mem_err(m64_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic accept();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata, input logic err);
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
    r64_valid = 0; r64_we = 0; r64_funct3 = 0; r64_addr = 0; r64_wdata = 0;
    m64_ready = 0; m64_rvalid = 0; m64_rdata = 0; m64_err = 0;
    repeat (2) tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    rst = 1'b0;
    tick();

    // LB 0x1003: byte 0x80 sign-extends
    issue(1'b0, 3'b000, 32'h1003, 32'h0);
    check("lb_mem_valid", mem_valid, 1);
    check("lb_mem_addr", mem_addr, 32'h1000);
    check("lb_mem_we", mem_we, 0);
    check("lb_req_ready", req_ready, 0);
    accept();
    check("lb_cmd_drop", mem_valid, 0);
    respond(32'h80FF_FF7F, 1'b0);
    check("lb_rsp_valid", rsp_valid, 1);
    check("lb_rsp_rdata", rsp_rdata, 32'hFFFF_FF80);
    check("lb_rsp_err", rsp_err, 0);
    tick();
    check("lb_pulse_end", rsp_valid, 0);
    check("lb_rdata_hold", rsp_rdata, 32'hFFFF_FF80);
    check("lb_ready_back", req_ready, 1);

    // SW with mem_ready stalled for 3 cycles
    issue(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      check("sw_stall_valid", mem_valid, 1);
      check("sw_stall_addr", mem_addr, 32'h20);
      check("sw_stall_wstrb", mem_wstrb, 4'hF);
      check("sw_stall_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("sw_stall_we", mem_we, 1);
      tick();
    end
    check("sw_held_addr", mem_addr, 32'h20);
    accept();
    respond(32'h1234_5678, 1'b0);
    check("sw_rsp_valid", rsp_valid, 1);
    check("sw_rsp_rdata", rsp_rdata, 0);
    check("sw_rsp_err", rsp_err, 0);
    tick();

    // SB at offset 1
    issue(1'b1, 3'b000, 32'h5, 32'h0000_00A5);
    check("sb_mem_addr", mem_addr, 32'h4);
    check("sb_mem_wstrb", mem_wstrb, 4'h2);
    check("sb_mem_wdata", mem_wdata, 32'h0000_A500);
    accept();
    respond(32'h0, 1'b0);
    tick();

    // Illegal LD on a 32-bit datapath: no bus access, response next cycle
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    check("ld32_mem_valid", mem_valid, 0);
    check("ld32_rsp_valid", rsp_valid, 1);
    check("ld32_rsp_err", rsp_err, 1);
    tick();
    issue(1'b1, 3'b011, 32'h10, 32'h0);
    check("sd32_rsp_err", rsp_err, 1);
    tick();

    // Bus error on beat 0
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    accept();
    respond(32'h1234_5678, 1'b1);
    check("merr_rsp_valid", rsp_valid, 1);
    check("merr_rsp_err", rsp_err, 1);
    check("merr_rsp_rdata", rsp_rdata, 0);
    tick();

    // Timeout after 4 cycles in RSP0, late rvalid ignored
    issue(1'b0, 3'b010, 32'h50, 32'h0);
    accept();
    repeat (3) tick();
    check("tmo_not_yet", rsp_valid, 0);
    tick();
    check("tmo_rsp_valid", rsp_valid, 1);
    check("tmo_rsp_err", rsp_err, 1);
    tick();
    respond(32'hAAAA_AAAA, 1'b0);
    check("tmo_late_ignored", rsp_valid, 0);
    check("tmo_late_ready", req_ready, 1);

    // LHU at offset 2 zero-extends
    issue(1'b0, 3'b101, 32'h106, 32'h0);
    check("lhu_mem_addr", mem_addr, 32'h104);
    accept();
    respond(32'h8001_1234, 1'b0);
    check("lhu_rsp_rdata", rsp_rdata, 32'h0000_8001);
    tick();

    // Reset asserted during RSP0, then a late rvalid
    issue(1'b0, 3'b010, 32'h60, 32'h0);
    accept();
    #2 rst = 1'b1;
    #1;
    check("rstmid_req_ready", req_ready, 1);
    check("rstmid_mem_valid", mem_valid, 0);
    check("rstmid_rsp_rdata", rsp_rdata, 0);
    check("rstmid_rsp_err", rsp_err, 0);
    #1 rst = 1'b0;
    respond(32'h5555_5555, 1'b0);
    check("rstmid_no_rsp", rsp_valid, 0);
    tick();
    check("rstmid_no_rsp2", rsp_valid, 0);
    check("rstmid_rdata0", rsp_rdata, 0);

`ifdef LSU_MISALIGN_EN
    // LW at offset 2 split across two beats
    issue(1'b0, 3'b010, 32'h2, 32'h0);
    check("mlw_beat0_addr", mem_addr, 32'h0);
    accept();
    respond(32'h4433_2211, 1'b0);
    check("mlw_beat1_valid", mem_valid, 1);
    check("mlw_beat1_addr", mem_addr, 32'h4);
    check("mlw_no_early_rsp", rsp_valid, 0);
    accept();
    respond(32'h8877_6655, 1'b0);
    check("mlw_rsp_valid", rsp_valid, 1);
    check("mlw_rsp_rdata", rsp_rdata, 32'h6655_4433);
    check("mlw_rsp_err", rsp_err, 0);
    tick();

    // SW at offset 3: one byte in beat 0, three in beat 1
    issue(1'b1, 3'b010, 32'h3, 32'hAABB_CCDD);
    check("msw_b0_wstrb", mem_wstrb, 4'h8);
    check("msw_b0_wdata", mem_wdata, 32'hDD00_0000);
    accept();
    respond(32'h0, 1'b0);
    check("msw_b1_addr", mem_addr, 32'h4);
    check("msw_b1_wstrb", mem_wstrb, 4'h7);
    check("msw_b1_wdata", mem_wdata, 32'h00AA_BBCC);
    accept();
    respond(32'h0, 1'b0);
    check("msw_rsp_valid", rsp_valid, 1);
    check("msw_rsp_err", rsp_err, 0);
    tick();
`else
    // Misaligned LW rejected without any bus access
    issue(1'b0, 3'b010, 32'h2, 32'h0);
    check("mlw_mem_valid", mem_valid, 0);
    check("mlw_rsp_valid", rsp_valid, 1);
    check("mlw_rsp_err", rsp_err, 1);
    tick();
    issue(1'b1, 3'b001, 32'h3, 32'h0);
    check("msh_mem_valid", mem_valid, 0);
    check("msh_rsp_err", rsp_err, 1);
    tick();
`endif

    // 64-bit SH at offset 6
    r64_we = 1'b1; r64_funct3 = 3'b001; r64_addr = 64'h6; r64_wdata = 64'hBEEF;
    r64_valid = 1'b1;
    tick();
    r64_valid = 1'b0;
    check("sh64_mem_valid", m64_valid, 1);
    check("sh64_mem_addr", m64_addr, 64'h0);
    check("sh64_mem_wstrb", m64_wstrb, 8'hC0);
    check("sh64_mem_wdata", m64_wdata, 64'hBEEF_0000_0000_0000);
    m64_ready = 1'b1; tick(); m64_ready = 1'b0;
    m64_rvalid = 1'b1; tick(); m64_rvalid = 1'b0;
    check("sh64_rsp_valid", r64_rsp_valid, 1);
    check("sh64_rsp_err", r64_rsp_err, 0);
    tick();

    // 64-bit LW at offset 4 sign-extends to 64 bits
    r64_we = 1'b0; r64_funct3 = 3'b010; r64_addr = 64'hC; r64_wdata = 64'h0;
    r64_valid = 1'b1;
    tick();
    r64_valid = 1'b0;
    check("lw64_mem_addr", m64_addr, 64'h8);
    m64_ready = 1'b1; tick(); m64_ready = 1'b0;
    m64_rvalid = 1'b1; m64_rdata = 64'h9000_0001_0000_0000; tick(); m64_rvalid = 1'b0;
    check("lw64_rsp_valid", r64_rsp_valid, 1);
    check("lw64_rsp_rdata", r64_rsp_rdata, 64'hFFFF_FFFF_9000_0001);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
